// File: rtl/aes_bist_sequencer.sv
// Built-in self-test sequencer for the AES cores. An LFSR generates the patterns and a
// MISR compacts the core results into a signature that is compared with a per-mode golden value.
module aes_bist_sequencer #(
  parameter int unsigned       DATA_W       = 128,
  parameter int unsigned       LFSR_W       = 32,
  parameter logic [LFSR_W-1:0] LFSR_POLY    = 32'h82608EDB,
  parameter int unsigned       SIG_W        = 32,
  parameter logic [SIG_W-1:0]  MISR_POLY    = 32'h04C11DB7,
  parameter logic [SIG_W-1:0]  MISR_SEED    = '0,
  parameter int unsigned       NUM_PATTERNS = 40,
  parameter int unsigned       TIMEOUT      = 1024,
  parameter logic [SIG_W-1:0]  GOLDEN_ENC   = 32'hBC52CEBF,
  parameter logic [SIG_W-1:0]  GOLDEN_DEC   = 32'h6081AF79
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bist_start,
  input  logic              bist_abort,
  input  logic              bist_mode,
  input  logic [LFSR_W-1:0] seed_in,
  input  logic [DATA_W-1:0] key_in,
  output logic              core_start,
  output logic              core_mode,
  output logic [DATA_W-1:0] core_data,
  output logic [DATA_W-1:0] core_key,
  input  logic              core_ready,
  input  logic [DATA_W-1:0] core_result,
  output logic              bist_busy,
  output logic              bist_done,
  output logic              bist_pass,
  output logic              bist_timeout,
  output logic [SIG_W-1:0]  signature,
  output logic [15:0]       pattern_count
);

  localparam int unsigned WPP    = DATA_W / LFSR_W;
  localparam int unsigned NSLICE = DATA_W / SIG_W;
  localparam int unsigned WW     = (WPP > 1) ? $clog2(WPP) : 1;
  localparam int unsigned TW     = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [WW-1:0] WORD_LAST = WW'(WPP - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);
  localparam logic [15:0]   PAT_LAST  = 16'(NUM_PATTERNS - 1);

  typedef enum logic [2:0] {
    IDLE,
    GEN,
    ISSUE,
    WAIT,
    CHECK
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [WW-1:0]     word_idx;
  logic [TW-1:0]     tcnt;
  logic [LFSR_W-1:0] lfsr;
  logic [LFSR_W-1:0] lfsr_next;
  logic [SIG_W-1:0]  fold;
  logic [SIG_W-1:0]  misr_next;
  logic              start_run;
  logic              gen_step;
  logic              compact;
  logic              end_timeout;
  logic              end_check;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Abort overrides every transition, so none of the run-ending strobes fire under it.
  always_comb begin
    state_next  = state;
    start_run   = 1'b0;
    gen_step    = 1'b0;
    compact     = 1'b0;
    end_timeout = 1'b0;
    end_check   = 1'b0;
    core_start  = (state == ISSUE);
    bist_busy   = (state != IDLE);
    if (bist_abort) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (bist_start) begin
            start_run  = 1'b1;
            state_next = GEN;
          end
        end
        GEN: begin
          gen_step = 1'b1;
          if (word_idx == WORD_LAST) begin
            state_next = ISSUE;
          end
        end
        ISSUE: begin
          state_next = WAIT;
        end
        WAIT: begin
          if (core_ready) begin
            compact    = 1'b1;
            state_next = (pattern_count == PAT_LAST) ? CHECK : GEN;
          end else if (tcnt == TO_LAST) begin
            end_timeout = 1'b1;
            state_next  = IDLE;
          end
        end
        CHECK: begin
          end_check  = 1'b1;
          state_next = IDLE;
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  always_comb begin
    lfsr_next = {^(lfsr & LFSR_POLY), lfsr[LFSR_W-1:1]};
    fold      = '0;
    for (int unsigned i = 0; i < NSLICE; i++) begin
      fold = fold ^ core_result[i*SIG_W +: SIG_W];
    end
    misr_next = {signature[SIG_W-2:0], ^(signature & MISR_POLY)} ^ fold;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr          <= '1;
      signature     <= MISR_SEED;
      word_idx      <= '0;
      tcnt          <= '0;
      core_data     <= '0;
      core_key      <= '0;
      core_mode     <= 1'b0;
      pattern_count <= '0;
      bist_done     <= 1'b0;
      bist_pass     <= 1'b0;
      bist_timeout  <= 1'b0;
    end else begin
      bist_done <= end_timeout | end_check;

      if (start_run) begin
        core_mode     <= bist_mode;
        core_key      <= key_in;
        lfsr          <= (seed_in == '0) ? '1 : seed_in;
        signature     <= MISR_SEED;
        pattern_count <= '0;
        word_idx      <= '0;
        bist_pass     <= 1'b0;
        bist_timeout  <= 1'b0;
      end

      if (gen_step) begin
        lfsr <= lfsr_next;
        core_data[int'(word_idx)*LFSR_W +: LFSR_W] <= lfsr_next;
        word_idx <= (word_idx == WORD_LAST) ? '0 : word_idx + 1'b1;
      end

      if (state == ISSUE) begin
        tcnt <= '0;
      end else if (state == WAIT) begin
        tcnt <= tcnt + 1'b1;
      end

      if (compact) begin
        signature     <= misr_next;
        pattern_count <= pattern_count + 16'd1;
      end

      if (end_timeout) begin
        bist_timeout <= 1'b1;
        bist_pass    <= 1'b0;
      end

      if (end_check) begin
        bist_pass <= (signature == (core_mode ? GOLDEN_DEC : GOLDEN_ENC));
      end
    end
  end

endmodule
